// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Arbitration is round-robin (MODE 0) or fixed lowest-index priority (MODE 1), with an optional forced select.
module stream_mux_rr #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 0,
  localparam int CH_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  force_en,
  input  logic [CH_W-1:0]       force_sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]  out_ch_q,    out_ch_d;
  logic [CH_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic             load;
  logic             hs;
  logic [N_CH-1:0]  elig;
  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [WIDTH-1:0] chan_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The output stage can accept a new word when empty or draining this cycle.
  assign load = !out_valid_q || out_ready;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    elig = in_valid;
    if (force_en) begin
      for (int i = 0; i < N_CH; i++) begin
        elig[i] = in_valid[i] && (force_sel == CH_W'(i));
      end
    end
  end

  // Scan from the round-robin pointer (or from 0 in priority mode), wrapping at N_CH.
  always_comb begin
    logic         found;
    int           cand;
    logic [CH_W-1:0] idx;
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    found      = 1'b0;
    cand       = 0;
    idx        = '0;
    if (rst_n && load) begin
      for (int k = 0; k < N_CH; k++) begin
        cand = (MODE == 0) ? int'(rr_ptr_q) + k : k;
        if (cand >= N_CH) cand = cand - N_CH;
        idx = CH_W'(cand);
        if (!found && elig[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx;
          grant_data = chan_data[idx];
        end
      end
    end
  end

  assign hs       = |grant;
  assign in_ready = grant;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = hs;
      if (hs) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        rr_ptr_d   = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin and a fixed-priority instance share stimulus and are checked
// every cycle against a queue-free behavioural model, plus directed literal expectations.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        force_en;
  logic [1:0]  force_sel;
  logic        out_ready;
  logic [7:0]  chd [4];

  logic [3:0]  rdy [2];
  logic        ov  [2];
  logic [7:0]  od  [2];
  logic [1:0]  oc  [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  logic       m_v [2];
  logic [7:0] m_d [2];
  int         m_c [2];
  int         m_p [2];

  assign in_data = {chd[3], chd[2], chd[1], chd[0]};

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .force_en(force_en), .force_sel(force_sel), .out_valid(ov[0]), .out_data(od[0]),
    .out_ch(oc[0]), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .force_en(force_en), .force_sel(force_sel), .out_valid(ov[1]), .out_data(od[1]),
    .out_ch(oc[1]), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Winning channel: first eligible one in rotation order starting at ptr (rr) or at 0 (priority).
  function automatic int pick(input logic [3:0] e, input int ptr, input int mode);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (mode == 1) ? k : (ptr + k) % 4;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    logic       ld;
    int         c;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_v[m] = 1'b0; m_d[m] = 8'h00; m_c[m] = 0; m_p[m] = 0;
        check($sformatf("m%0d rst in_ready", m), rdy[m], 0);
        check($sformatf("m%0d rst out_valid", m), ov[m], 0);
      end else begin
        e  = force_en ? (in_valid & (4'b0001 << force_sel)) : in_valid;
        ld = !m_v[m] || out_ready;
        c  = ld ? pick(e, m_p[m], m) : -1;
        check($sformatf("m%0d in_ready", m), rdy[m], (c >= 0) ? (32'd1 << c) : 32'd0);
        check($sformatf("m%0d out_valid", m), ov[m], m_v[m]);
        check($sformatf("m%0d out_data", m), od[m], m_d[m]);
        check($sformatf("m%0d out_ch", m), oc[m], m_c[m]);
        if (ld) begin
          if (c >= 0) begin
            m_v[m] = 1'b1; m_d[m] = chd[c]; m_c[m] = c; m_p[m] = (c + 1) % 4;
          end else begin
            m_v[m] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; force_en = 1'b0; force_sel = 2'd0;
    for (int i = 0; i < 4; i++) chd[i] = 8'hA0 + 8'(i);
    #1;
    check("reset out_valid rr", ov[0], 0);
    check("reset out_valid fp", ov[1], 0);
    check("reset in_ready rr", rdy[0], 0);
    check("reset out_ch rr", oc[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("first grant rr", rdy[0], 4'b0001);
    check("first grant fp", rdy[1], 4'b0001);
    tick();
    check("rr first word ch", oc[0], 0);
    check("rr first word data", od[0], 8'hA0);
    check("rr next ready", rdy[0], 4'b0010);

    // Round-robin rotation, one word per cycle.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rr rotate ch", oc[0], k % 4);
      check("rr rotate data", od[0], 8'hA0 + k % 4);
      check("fp stays ch0", oc[1], 0);
    end

    // Backpressure with A1 held.
    tick();
    check("bp held data", od[0], 8'hA1);
    out_ready = 1'b0;
    #1;
    check("bp in_ready low", rdy[0], 0);
    repeat (3) begin
      tick();
      check("bp data stays", od[0], 8'hA1);
      check("bp valid stays", ov[0], 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp reload ready", rdy[0], 4'b0100);
    tick();
    check("bp drain+load data", od[0], 8'hA2);

    // Forced select.
    force_en = 1'b1; force_sel = 2'd2;
    #1;
    check("force ready", rdy[0], 4'b0100);
    tick();
    check("force ch a", oc[0], 2);
    check("force fp ch", oc[1], 2);
    tick();
    check("force ch b", oc[0], 2);
    force_sel = 2'd3; in_valid = 4'b0111;
    #1;
    check("force empty ready", rdy[0], 0);
    tick();
    check("force empty valid", ov[0], 0);
    force_en = 1'b0; in_valid = 4'hF;
    #1;
    check("unforce ready", rdy[0], 4'b1000);
    tick();
    check("unforce ch", oc[0], 3);

    // Fixed priority starvation.
    in_valid = 4'b1010;
    #1;
    check("fp prio ready", rdy[1], 4'b0010);
    repeat (3) begin
      tick();
      check("fp prio ch1", oc[1], 1);
    end
    in_valid = 4'b1000;
    tick();
    check("fp starved ch3", oc[1], 3);

    // Reset while a word is held.
    in_valid = 4'hF; out_ready = 1'b0;
    tick();
    check("pre-reset valid", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset valid rr", ov[0], 0);
    check("mid reset valid fp", ov[1], 0);
    check("mid reset ready", rdy[0], 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("restart ready", rdy[0], 4'b0001);
    tick();
    check("restart ch", oc[0], 0);
    check("restart data", od[0], 8'hA0);

    // Randomized traffic checked by the model every cycle.
    repeat (3000) begin
      tick();
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      force_en  = ($urandom_range(0, 9) == 0);
      force_sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) chd[i] = 8'($urandom);
    end
    rst_n = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
